// File: rtl/line_sched_if.sv
// Pixel-in / line-out handshake bundle for the ping-pong line-buffer controller.
// The controller uses the slave view; the pixel core and VGA side use the master view.
interface line_sched_if;
    logic       pix_valid_i;
    logic       pix_ready_o;
    logic       wr_en_o;
    logic       wr_bank_o;
    logic [9:0] wr_addr_o;
    logic       line_valid_o;
    logic       rd_bank_o;
    logic [9:0] line_row_o;
    logic       line_ack_i;

    modport slave (
        input  pix_valid_i,
        input  line_ack_i,
        output pix_ready_o,
        output wr_en_o,
        output wr_bank_o,
        output wr_addr_o,
        output line_valid_o,
        output rd_bank_o,
        output line_row_o
    );

    modport master (
        output pix_valid_i,
        output line_ack_i,
        input  pix_ready_o,
        input  wr_en_o,
        input  wr_bank_o,
        input  wr_addr_o,
        input  line_valid_o,
        input  rd_bank_o,
        input  line_row_o
    );
endinterface

// File: rtl/line_sched.sv
// Ping-pong line-buffer controller: steers core pixels into two line banks,
// presents completed lines to the VGA side until acknowledged, and stalls the
// core while both banks hold unread lines.
module line_sched #(
    parameter int MAX_COL = 540,
    parameter int MAX_ROW = 540
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    line_sched_if.slave bus,
    output logic [9:0]  row_cnt_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam logic [9:0] COL_LAST = 10'(MAX_COL - 1);
    localparam logic [9:0] ROW_LAST = 10'(MAX_ROW - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t     state_q;
    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic [9:0] row_cnt_q, row_cnt_d;
    logic [9:0] line_row_q, line_row_d;
    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic       busy_q;
    logic       frame_done_q;

    logic       pix_ready;
    logic       accept;
    logic       ack_fire;
    logic       last_col;
    logic       last_row;

    // A bank that still holds an unread line must not be overwritten, so the
    // core is only accepted while filling and the target bank is empty.
    assign pix_ready = (state_q == FILL) && !full_q[wr_bank_q];
    assign accept    = bus.pix_valid_i && pix_ready;
    assign ack_fire  = bus.line_ack_i && full_q[rd_bank_q];
    assign last_col  = (col_q == COL_LAST);
    assign last_row  = (row_q == ROW_LAST);

    // Datapath next state: write-side column/row/bank and read-side bank/counters.
    // A last-pixel write and an ack touch different banks, so both apply together.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        row_cnt_d  = row_cnt_q;
        line_row_d = line_row_q;
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        if (state_q == IDLE) begin
            if (start_i) begin
                col_d      = '0;
                row_d      = '0;
                row_cnt_d  = '0;
                line_row_d = '0;
                full_d     = '0;
                wr_bank_d  = 1'b0;
                rd_bank_d  = 1'b0;
            end
        end else begin
            if (accept) begin
                if (last_col) begin
                    col_d             = '0;
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    if (!last_row) begin
                        row_d = row_q + 10'd1;
                    end
                end else begin
                    col_d = col_q + 10'd1;
                end
            end
            if (ack_fire) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                row_cnt_d         = row_cnt_q + 10'd1;
                line_row_d        = line_row_q + 10'd1;
            end
        end
    end

    // Frame FSM with registered busy/frame-done outputs, plus datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            row_cnt_q    <= '0;
            line_row_q   <= '0;
            full_q       <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            row_cnt_q  <= row_cnt_d;
            line_row_q <= line_row_d;
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= FILL;
                        busy_q  <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept && last_col && last_row) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ack_fire && (row_cnt_q == ROW_LAST)) begin
                        state_q      <= DONE;
                        frame_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pix_ready_o  = pix_ready;
    assign bus.wr_en_o      = accept;
    assign bus.wr_bank_o    = wr_bank_q;
    assign bus.wr_addr_o    = col_q;
    assign bus.line_valid_o = full_q[rd_bank_q];
    assign bus.rd_bank_o    = rd_bank_q;
    assign bus.line_row_o   = line_row_q;
    assign row_cnt_o        = row_cnt_q;
    assign busy_o           = busy_q;
    assign frame_done_o     = frame_done_q;

endmodule

// File: tb/tb_line_sched.sv
// Self-checking bench for line_sched with 4-pixel lines and 3-line frames.
// Expected writes and line presentations are queued as stimulus is driven and
// compared by a monitor when the DUT writes a pixel or takes an ack.
module tb_line_sched;

    localparam int MC = 4;
    localparam int MR = 3;

    typedef struct {
        logic       bank;
        logic [9:0] addr;
    } pixExpT;

    typedef struct {
        logic       bank;
        logic [9:0] row;
    } lineExpT;

    logic       clk;
    logic       rstN;
    logic       start;
    logic [9:0] rowCnt;
    logic       busy;
    logic       frameDone;

    int errCount   = 0;
    int checkCount = 0;
    int doneCount  = 0;
    int pixIdx     = 0;
    int ackIdx     = 0;

    pixExpT  expPix[$];
    lineExpT expLine[$];

    line_sched_if busIf ();

    line_sched #(.MAX_COL(MC), .MAX_ROW(MR)) dut (
        .clk          (clk),
        .rst_n        (rstN),
        .start_i      (start),
        .bus          (busIf),
        .row_cnt_o    (rowCnt),
        .busy_o       (busy),
        .frame_done_o (frameDone)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case some wait is never satisfied
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at a falling edge, then return them to idle
    task automatic applyStimulus(input logic v, input logic a, input logic s);
        busIf.pix_valid_i = v;
        busIf.line_ack_i  = a;
        start             = s;
        @(negedge clk);
        busIf.pix_valid_i = 1'b0;
        busIf.line_ack_i  = 1'b0;
        start             = 1'b0;
    endtask

    task automatic startFrame();
        applyStimulus(1'b0, 1'b0, 1'b1);
        pixIdx = 0;
        ackIdx = 0;
        checkOutput("startReady", 32'(busIf.pix_ready_o), 32'd1);
        checkOutput("startBusy", 32'(busy), 32'd1);
    endtask

    // Offer the next pixel of the frame until accepted; optionally ack in the first cycle
    task automatic sendPixel(input logic withAck);
        pixExpT e;
        int     cnt;
        e.bank = 1'((pixIdx / MC) % 2);
        e.addr = 10'(pixIdx % MC);
        expPix.push_back(e);
        pixIdx++;
        busIf.pix_valid_i = 1'b1;
        if (withAck) busIf.line_ack_i = 1'b1;
        cnt = 0;
        while (!busIf.pix_ready_o && cnt < 100) begin
            @(negedge clk);
            if (withAck) busIf.line_ack_i = 1'b0;
            cnt++;
        end
        if (!busIf.pix_ready_o) begin
            checkOutput("pixTimeout", 32'd0, 32'd1);
            busIf.pix_valid_i = 1'b0;
            return;
        end
        @(negedge clk);
        busIf.pix_valid_i = 1'b0;
        if (withAck) busIf.line_ack_i = 1'b0;
    endtask

    // Wait for a presented line, then acknowledge it for one cycle
    task automatic sendAck();
        lineExpT e;
        int      cnt;
        cnt = 0;
        while (!busIf.line_valid_o && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        if (!busIf.line_valid_o) begin
            checkOutput("ackTimeout", 32'd0, 32'd1);
            return;
        end
        e.bank = 1'(ackIdx % 2);
        e.row  = 10'(ackIdx);
        expLine.push_back(e);
        ackIdx++;
        busIf.line_ack_i = 1'b1;
        @(negedge clk);
        busIf.line_ack_i = 1'b0;
    endtask

    // Expect the end-of-frame pulse now or soon, lasting exactly one cycle
    task automatic waitDone();
        int cnt;
        cnt = 0;
        while (!frameDone && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("doneSeen", 32'(frameDone), 32'd1);
        checkOutput("doneRowCnt", 32'(rowCnt), 32'(MR));
        checkOutput("doneBusy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("donePulse", 32'(frameDone), 32'd0);
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("holdRowCnt", 32'(rowCnt), 32'(MR));
        checkOutput("idleReady", 32'(busIf.pix_ready_o), 32'd0);
    endtask

    // Monitor: compare each write and each accepted ack against the queued expectation
    always @(negedge clk) begin
        pixExpT  pe;
        lineExpT le;
        #2;
        if (busIf.wr_en_o) begin
            if (expPix.size() == 0) begin
                checkOutput("wrUnexpected", 32'd1, 32'd0);
            end else begin
                pe = expPix.pop_front();
                checkOutput("wrBank", 32'(busIf.wr_bank_o), 32'(pe.bank));
                checkOutput("wrAddr", 32'(busIf.wr_addr_o), 32'(pe.addr));
            end
        end
        if (busIf.line_ack_i && busIf.line_valid_o) begin
            if (expLine.size() == 0) begin
                checkOutput("ackUnexpected", 32'd1, 32'd0);
            end else begin
                le = expLine.pop_front();
                checkOutput("rdBank", 32'(busIf.rd_bank_o), 32'(le.bank));
                checkOutput("lineRow", 32'(busIf.line_row_o), 32'(le.row));
            end
        end
        if (frameDone) doneCount++;
    end

    initial begin
        rstN              = 1'b0;
        start             = 1'b0;
        busIf.pix_valid_i = 1'b0;
        busIf.line_ack_i  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        checkOutput("rstReady", 32'(busIf.pix_ready_o), 32'd0);
        checkOutput("rstWrEn", 32'(busIf.wr_en_o), 32'd0);
        checkOutput("rstWrBank", 32'(busIf.wr_bank_o), 32'd0);
        checkOutput("rstWrAddr", 32'(busIf.wr_addr_o), 32'd0);
        checkOutput("rstLineValid", 32'(busIf.line_valid_o), 32'd0);
        checkOutput("rstRdBank", 32'(busIf.rd_bank_o), 32'd0);
        checkOutput("rstLineRow", 32'(busIf.line_row_o), 32'd0);
        checkOutput("rstRowCnt", 32'(rowCnt), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDone", 32'(frameDone), 32'd0);
        rstN = 1'b1;
        @(negedge clk);

        // Frame A: single line, spurious inputs, back-pressure, drain
        startFrame();
        sendPixel(1'b0);
        sendPixel(1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("spurAddr", 32'(busIf.wr_addr_o), 32'd2);
        checkOutput("spurRowCnt", 32'(rowCnt), 32'd0);
        checkOutput("spurLineRow", 32'(busIf.line_row_o), 32'd0);
        checkOutput("spurRdBank", 32'(busIf.rd_bank_o), 32'd0);
        checkOutput("spurReady", 32'(busIf.pix_ready_o), 32'd1);
        sendPixel(1'b0);
        sendPixel(1'b0);
        checkOutput("line0Valid", 32'(busIf.line_valid_o), 32'd1);
        checkOutput("line0RdBank", 32'(busIf.rd_bank_o), 32'd0);
        checkOutput("line0Row", 32'(busIf.line_row_o), 32'd0);
        checkOutput("line0WrBank", 32'(busIf.wr_bank_o), 32'd1);
        for (int i = 0; i < MC; i++) sendPixel(1'b0);
        checkOutput("bpReady", 32'(busIf.pix_ready_o), 32'd0);
        checkOutput("bpWrBank", 32'(busIf.wr_bank_o), 32'd0);
        busIf.pix_valid_i = 1'b1;
        #1;
        checkOutput("bpWrEn", 32'(busIf.wr_en_o), 32'd0);
        @(negedge clk);
        checkOutput("bpReadyHold", 32'(busIf.pix_ready_o), 32'd0);
        checkOutput("bpWrEnHold", 32'(busIf.wr_en_o), 32'd0);
        busIf.pix_valid_i = 1'b0;
        sendAck();
        checkOutput("bpReleaseReady", 32'(busIf.pix_ready_o), 32'd1);
        checkOutput("bpReleaseRdBank", 32'(busIf.rd_bank_o), 32'd1);
        checkOutput("bpReleaseRowCnt", 32'(rowCnt), 32'd1);
        checkOutput("bpReleaseValid", 32'(busIf.line_valid_o), 32'd1);
        for (int i = 0; i < MC; i++) sendPixel(1'b0);
        checkOutput("drainReady", 32'(busIf.pix_ready_o), 32'd0);
        sendAck();
        sendAck();
        waitDone();

        // Frame B: last pixel of bank 1 written in the same edge as the bank 0 ack
        startFrame();
        for (int i = 0; i < 2 * MC - 1; i++) sendPixel(1'b0);
        expLine.push_back('{bank: 1'b0, row: 10'd0});
        ackIdx = 1;
        sendPixel(1'b1);
        checkOutput("simRdBank", 32'(busIf.rd_bank_o), 32'd1);
        checkOutput("simValid", 32'(busIf.line_valid_o), 32'd1);
        checkOutput("simRowCnt", 32'(rowCnt), 32'd1);
        checkOutput("simWrBank", 32'(busIf.wr_bank_o), 32'd0);
        checkOutput("simReady", 32'(busIf.pix_ready_o), 32'd1);
        for (int i = 0; i < MC; i++) sendPixel(1'b0);
        sendAck();
        sendAck();
        waitDone();

        // Frame D: reset mid-fill with one bank full discards everything
        startFrame();
        for (int i = 0; i < 2 * MC; i++) sendPixel(1'b0);
        sendAck();
        sendPixel(1'b0);
        checkOutput("preRstAddr", 32'(busIf.wr_addr_o), 32'd1);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("midRstValid", 32'(busIf.line_valid_o), 32'd0);
        checkOutput("midRstReady", 32'(busIf.pix_ready_o), 32'd0);
        checkOutput("midRstAddr", 32'(busIf.wr_addr_o), 32'd0);
        checkOutput("midRstRdBank", 32'(busIf.rd_bank_o), 32'd0);
        checkOutput("midRstLineRow", 32'(busIf.line_row_o), 32'd0);
        checkOutput("midRstRowCnt", 32'(rowCnt), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("needStartReady", 32'(busIf.pix_ready_o), 32'd0);
        checkOutput("needStartBusy", 32'(busy), 32'd0);

        // Frame C: random pixel gaps and random ack delays
        startFrame();
        fork
            begin
                for (int i = 0; i < MC * MR; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    sendPixel(1'b0);
                end
            end
            begin
                for (int j = 0; j < MR; j++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    sendAck();
                end
            end
        join
        waitDone();

        checkOutput("pixLeft", 32'(expPix.size()), 32'd0);
        checkOutput("lineLeft", 32'(expLine.size()), 32'd0);
        checkOutput("doneCount", 32'(doneCount), 32'd3);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/line_sched.md
# line_sched

Ping-pong line-buffer controller between the pixel core and the VGA line output. Accepts one processed pixel per cycle from the core, steers it into one of two 540-entry line banks, and presents each completed line to the VGA side until acknowledged. Back-pressures the core when both banks hold unread lines. Reports completed-line count to the seven-segment path and signals end of frame.

## Interface
- MAX_COL, 540, pixels per line; bank depth
- MAX_ROW, 540, lines per frame
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start_i  in  1  begin a frame; honoured only in IDLE
- pix_valid_i  in  1  core presents a pixel
- pix_ready_o  out  1  controller can accept a pixel this cycle
- wr_en_o  out  1  bank write strobe, equal to pix_valid_i & pix_ready_o (combinational)
- wr_bank_o  out  1  bank being filled
- wr_addr_o  out  10  column address of the current write
- line_valid_o  out  1  a full line is held in rd_bank_o
- rd_bank_o  out  1  bank presented to VGA
- line_row_o  out  10  row index of the presented line
- line_ack_i  in  1  VGA finished reading the presented line
- row_cnt_o  out  10  lines acknowledged so far this frame (to seven-segment)
- busy_o  out  1  high in every state except IDLE
- frame_done_o  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, FILL, DRAIN, DONE.
- IDLE: start_i=1 -> FILL; clears col, row, row_cnt, both full flags, wr_bank=0, rd_bank=0. start_i outside IDLE ignored.
- Accept = pix_valid_i & pix_ready_o. pix_ready_o = (state==FILL) & ~full[wr_bank].
- On accept: col+1. If col==MAX_COL-1: col<=0, full[wr_bank]<=1, wr_bank toggles, row+1; if also row==MAX_ROW-1 -> DRAIN (row not incremented past MAX_ROW-1).
- wr_addr_o = col; wr_bank_o = wr_bank.
- line_valid_o = full[rd_bank]. line_row_o increments with each ack, starts 0.
- On line_ack_i & line_valid_o: full[rd_bank]<=0, rd_bank toggles, row_cnt+1, line_row+1. line_ack_i with line_valid_o=0 ignored.
- DRAIN: no accepts; when ack brings row_cnt to MAX_ROW -> DONE.
- DONE: frame_done_o=1 for exactly this cycle; next cycle -> IDLE. row_cnt_o holds MAX_ROW until next start_i.
- Simultaneous last-pixel write and ack: both take effect in the same edge (always different banks; same-bank conflict impossible since a full bank cannot be written and an empty bank cannot be acked).
- Counters 10-bit unsigned; col never exceeds MAX_COL-1, row never exceeds MAX_ROW-1.

## Timing
- Reset (rst_n=0 at edge): state=IDLE, all flags/counters 0; outputs pix_ready_o=0, wr_en_o=0, wr_bank_o=0, wr_addr_o=0, line_valid_o=0, rd_bank_o=0, line_row_o=0, row_cnt_o=0, busy_o=0, frame_done_o=0. Reset mid-frame discards both banks' status immediately.
- start_i sampled at edge N -> pix_ready_o high from cycle N+1.
- Last pixel of a line accepted at edge N -> line_valid_o high in cycle N+1.
- Ack at edge N -> line_valid_o reflects the other bank in cycle N+1.
- Both banks full: pix_ready_o low the cycle after the second fill; rises the cycle after the next ack.
- Sustained throughput: one pixel/cycle when VGA acks each line within MAX_COL cycles of line_valid_o.
- Final ack at edge N -> DONE in N+1 (frame_done_o=1), IDLE in N+2.

## Test plan
- Reset: drive rst_n=0 mid-FILL with one bank full -> next cycle all outputs 0, state IDLE, start_i required to resume.
- Single line (MAX_COL=4, MAX_ROW=2): start, 4 valid pixels back-to-back -> wr_addr_o 0,1,2,3 on bank 0; line_valid_o=1, rd_bank_o=0, line_row_o=0 one cycle later; ack -> row_cnt_o=1.
- Back-pressure: no acks, 8 pixels offered with MAX_COL=4 -> both banks full, pix_ready_o=0, 9th pixel not written; one ack -> pix_ready_o=1 next cycle, writes go to bank 0.
- Simultaneous: last pixel of bank 1 accepted in same cycle as ack of bank 0 -> full={1,0}→{0,1} transition correct, rd_bank_o=1, line_valid_o stays 1.
- Full frame (MAX_COL=4, MAX_ROW=3): 12 pixels with random valid gaps, acks with random delay -> exactly 3 acks accepted, line_row_o 0,1,2, frame_done_o single pulse, row_cnt_o=3, busy_o falls.
- Spurious inputs: line_ack_i with line_valid_o=0, start_i during FILL -> no state change.
